// File: rtl/factorial_engine_if.sv
// Start/result bundle for factorial_engine.
// The master drives go/n; the slave returns result, status and overflow.
interface factorial_engine_if #(
  parameter int WIDTH   = 32,
  parameter int N_WIDTH = 5
);
  logic               go;
  logic [N_WIDTH-1:0] n;
  logic [WIDTH-1:0]   result;
  logic               done;
  logic               busy;
  logic               ovf;

  modport master (
    output go,
    output n,
    input  result,
    input  done,
    input  busy,
    input  ovf
  );

  modport slave (
    input  go,
    input  n,
    output result,
    output done,
    output busy,
    output ovf
  );
endinterface

// File: rtl/factorial_engine.sv
// Iterative n! engine: one multiply per cycle, counting n down to 1.
// Overflow is sticky per operation; optional saturation on completion.
module factorial_engine #(
  parameter int WIDTH    = 32,
  parameter int N_WIDTH  = 5,
  parameter bit SATURATE = 1'b0
) (
  input  logic             CLK,
  input  logic             rst,
  factorial_engine_if.slave bus
);

  localparam int PW = WIDTH + N_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;

  logic [PW-1:0]      full;
  logic               hi_set;
  logic               last;

  // Full-width product so bits above WIDTH are visible for overflow.
  assign full   = PW'(prod_q) * PW'(cnt_q);
  assign hi_set = |full[PW-1:WIDTH];
  assign last   = (cnt_q <= N_WIDTH'(1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    result_d = result_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.go) begin
          cnt_d    = bus.n;
          prod_d   = WIDTH'(1);
          sticky_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_d  = DONE;
          ovf_d    = sticky_q;
          result_d = (SATURATE && sticky_q) ? '1 : prod_q;
        end else begin
          prod_d   = full[WIDTH-1:0];
          cnt_d    = cnt_q - N_WIDTH'(1);
          sticky_d = sticky_q | hi_set;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      result_q <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = (state_q == DONE);
  assign bus.busy   = (state_q != IDLE);

endmodule
